// File: rtl/button_press_classifier_pkg.sv
// Shared state encoding and default timing constants for the button gesture classifier.
// Defaults are sized for a 50 MHz core clock.
package btn_pkg;

  localparam int LONG_CNT_DEF = 50_000_000;
  localparam int GAP_CNT_DEF  = 12_500_000;
  localparam int CNT_W_DEF    = 26;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_PRESS1 = 3'd1;
  localparam logic [2:0] ST_GAP    = 3'd2;
  localparam logic [2:0] ST_PRESS2 = 3'd3;
  localparam logic [2:0] ST_HOLD   = 3'd4;

endpackage

// File: rtl/button_press_classifier_timer.sv
// Up-counter with clear and enable; done is combinational from the count (cnt == term-1).
// Clear has priority over enable; synchronous active-high reset.
module btn_timer #(
  parameter int CNT_W = 26
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] term,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done = (cnt_q == term - CNT_W'(1));

endmodule

// File: rtl/button_press_classifier.sv
// Classifies debounced presses into short/long/double events; all outputs registered (1 cycle after decision).
// Double-click support (GAP/PRESS2 states, double_tick) is built only when BTN_DOUBLE_CLICK_EN is defined.
module button_press_classifier
  import btn_pkg::*;
#(
  parameter int LONG_CNT = LONG_CNT_DEF,
  parameter int GAP_CNT  = GAP_CNT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic db_tick,
  input  logic db_level,
  output logic short_tick,
  output logic long_tick,
  output logic double_tick,
  output logic hold_level,
  output logic busy
);

  logic [2:0] state_q, state_d;
  logic       short_q, short_d;
  logic       long_q, long_d;
  logic       hold_q, hold_d;
  logic       busy_q, busy_d;
  logic       done;
  logic [CNT_W-1:0] term;

  // The timer restarts on every state change and only runs while timing a press or a gap.
  assign term = (state_q == ST_GAP) ? CNT_W'(GAP_CNT) : CNT_W'(LONG_CNT);

  btn_timer #(.CNT_W(CNT_W)) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (state_d != state_q),
    .en    ((state_q == ST_PRESS1) || (state_q == ST_GAP)),
    .term  (term),
    .done  (done)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (db_tick) state_d = ST_PRESS1;
      ST_PRESS1: begin
        if (!db_level) begin
`ifdef BTN_DOUBLE_CLICK_EN
          state_d = ST_GAP;
`else
          state_d = ST_IDLE;
`endif
        end else if (done) begin
          state_d = ST_HOLD;
        end
      end
`ifdef BTN_DOUBLE_CLICK_EN
      ST_GAP: begin
        if (db_tick) begin
          state_d = ST_PRESS2;
        end else if (done) begin
          state_d = ST_IDLE;
        end
      end
      ST_PRESS2: if (!db_level) state_d = ST_IDLE;
`endif
      ST_HOLD: if (!db_level) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef BTN_DOUBLE_CLICK_EN
  logic dbl_q, dbl_d;
`endif

  always_comb begin
    short_d = 1'b0;
    long_d  = 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
    dbl_d   = 1'b0;
`endif
    case (state_q)
      ST_PRESS1: begin
`ifndef BTN_DOUBLE_CLICK_EN
        short_d = ~db_level;
`endif
        long_d  = db_level & done;
      end
`ifdef BTN_DOUBLE_CLICK_EN
      // A second press on the timeout cycle still counts as a double click.
      ST_GAP: begin
        dbl_d   = db_tick;
        short_d = ~db_tick & done;
      end
`endif
      default: ;
    endcase
    hold_d = (state_d == ST_HOLD);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      short_q <= 1'b0;
      long_q  <= 1'b0;
      hold_q  <= 1'b0;
      busy_q  <= 1'b0;
`ifdef BTN_DOUBLE_CLICK_EN
      dbl_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      short_q <= short_d;
      long_q  <= long_d;
      hold_q  <= hold_d;
      busy_q  <= busy_d;
`ifdef BTN_DOUBLE_CLICK_EN
      dbl_q   <= dbl_d;
`endif
    end
  end

  assign short_tick = short_q;
  assign long_tick  = long_q;
  assign hold_level = hold_q;
  assign busy       = busy_q;
`ifdef BTN_DOUBLE_CLICK_EN
  assign double_tick = dbl_q;
`else
  assign double_tick = 1'b0;
`endif

endmodule

// File: tb/tb_button_press_classifier.sv
// Directed bench for button_press_classifier with LONG_CNT=8, GAP_CNT=5; expectations follow BTN_DOUBLE_CLICK_EN.
module tb_button_press_classifier;

  logic clk = 1'b0;
  logic reset, db_tick, db_level;
  logic short_tick, long_tick, double_tick, hold_level, busy;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  button_press_classifier #(.LONG_CNT(8), .GAP_CNT(5), .CNT_W(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .db_tick     (db_tick),
    .db_level    (db_level),
    .short_tick  (short_tick),
    .long_tick   (long_tick),
    .double_tick (double_tick),
    .hold_level  (hold_level),
    .busy        (busy)
  );

  // First press: db_tick at 10, level high from 11 until rel1-1. Optional second press at tick2,
  // level high tick2+1 .. rel2-1. Event cycles of 0 mean "never"; ranges are inclusive.
  typedef struct {
    string name;
    int rel1, tick2, rel2, rst;
    int sh1, sh2, lg, dbl;
    int hlo, hhi;
    int b1lo, b1hi, b2lo, b2hi;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

`ifdef BTN_DOUBLE_CLICK_EN
  localparam int SHK = 6;
`else
  localparam int SHK = 1;
`endif

  function automatic logic in_rng(input int c, input int lo, input int hi);
    return (lo != 0) && (c >= lo) && (c <= hi);
  endfunction

  task automatic chk(input string sc, input string nm, input int c, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s cycle %0d: got %b expected %b", sc, nm, c, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic t, input logic l);
    reset = r; db_tick = t; db_level = l;
    @(posedge clk); #1;
  endtask

  initial begin
`ifdef BTN_DOUBLE_CLICK_EN
    tbl[0] = '{"short",           14,  0,  0,  0, 20,  0,  0,  0,  0,  0, 11, 19,  0,  0};
    tbl[1] = '{"long",            30,  0,  0,  0,  0,  0, 19,  0, 19, 30, 11, 30,  0,  0};
    tbl[2] = '{"double",          14, 17, 22,  0,  0,  0,  0, 18,  0,  0, 11, 22,  0,  0};
    tbl[3] = '{"tie",             14, 19, 23,  0,  0,  0,  0, 20,  0,  0, 11, 23,  0,  0};
    tbl[4] = '{"rst_gap",         14, 25, 27, 16, 33,  0,  0,  0,  0,  0, 11, 16, 26, 32};
    tbl[5] = '{"rst_hold",        30,  0,  0, 22,  0,  0, 19,  0, 19, 22, 11, 22,  0,  0};
    tbl[6] = '{"rst_press1",      30,  0,  0, 16,  0,  0,  0,  0,  0,  0, 11, 16,  0,  0};
    tbl[7] = '{"rel_at_term",     18,  0,  0,  0, 24,  0,  0,  0,  0,  0, 11, 23,  0,  0};
    tbl[8] = '{"long_min",        19,  0,  0,  0,  0,  0, 19,  0, 19, 19, 11, 19,  0,  0};
    tbl[9] = '{"retick_at_short", 14, 20, 23,  0, 20, 29,  0,  0,  0,  0, 11, 19, 21, 28};
`else
    tbl[0] = '{"short",           14,  0,  0,  0, 15,  0,  0,  0,  0,  0, 11, 14,  0,  0};
    tbl[1] = '{"long",            30,  0,  0,  0,  0,  0, 19,  0, 19, 30, 11, 30,  0,  0};
    tbl[2] = '{"double",          14, 17, 22,  0, 15, 23,  0,  0,  0,  0, 11, 14, 18, 22};
    tbl[3] = '{"tie",             14, 19, 23,  0, 15, 24,  0,  0,  0,  0, 11, 14, 20, 23};
    tbl[4] = '{"rst_gap",         14, 25, 27, 16, 15, 28,  0,  0,  0,  0, 11, 14, 26, 27};
    tbl[5] = '{"rst_hold",        30,  0,  0, 22,  0,  0, 19,  0, 19, 22, 11, 22,  0,  0};
    tbl[6] = '{"rst_press1",      30,  0,  0, 16,  0,  0,  0,  0,  0,  0, 11, 16,  0,  0};
    tbl[7] = '{"rel_at_term",     18,  0,  0,  0, 19,  0,  0,  0,  0,  0, 11, 18,  0,  0};
    tbl[8] = '{"long_min",        19,  0,  0,  0,  0,  0, 19,  0, 19, 19, 11, 19,  0,  0};
    tbl[9] = '{"retick_at_short", 14, 20, 23,  0, 15, 24,  0,  0,  0,  0, 11, 14, 21, 23};
`endif

    reset = 1'b1; db_tick = 1'b0; db_level = 1'b0;
    @(posedge clk); #1;

    for (int s = 0; s < NV; s++) begin
      for (int c = 0; c <= 40; c++) begin
        reset    = (c < 2) || (c == tbl[s].rst);
        db_tick  = (c == 10) || (tbl[s].tick2 != 0 && c == tbl[s].tick2);
        db_level = (c >= 11 && c < tbl[s].rel1) ||
                   (tbl[s].tick2 != 0 && c > tbl[s].tick2 && c < tbl[s].rel2);
        if (c >= 2) begin
          chk(tbl[s].name, "short_tick",  c, short_tick,  (c == tbl[s].sh1) || (c == tbl[s].sh2));
          chk(tbl[s].name, "long_tick",   c, long_tick,   c == tbl[s].lg);
          chk(tbl[s].name, "double_tick", c, double_tick, c == tbl[s].dbl);
          chk(tbl[s].name, "hold_level",  c, hold_level,  in_rng(c, tbl[s].hlo, tbl[s].hhi));
          chk(tbl[s].name, "busy",        c, busy,
              in_rng(c, tbl[s].b1lo, tbl[s].b1hi) || in_rng(c, tbl[s].b2lo, tbl[s].b2hi));
        end
        @(posedge clk); #1;
      end
    end

    // Reset wins over a simultaneous press, then a short press is timed from its release.
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk("seq", "reset_busy", 0, busy, 1'b0);
    chk("seq", "reset_short", 0, short_tick, 1'b0);
    step(1'b1, 1'b1, 1'b0);
    chk("seq", "tick_in_reset_busy", 1, busy, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    chk("seq", "press_busy", 2, busy, 1'b1);
    chk("seq", "press_short", 2, short_tick, 1'b0);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      chk("seq", "release_short", k, short_tick, k == SHK);
      chk("seq", "release_double", k, double_tick, 1'b0);
      chk("seq", "release_busy", k, busy, k < SHK);
      step(1'b0, 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
